// File: rtl/video_pipe_ctrl_if.sv
// Signal bundle between the frame timing / host configuration side and video_pipe_ctrl.
interface video_pipe_ctrl_if;
   logic        per_frame_vsync;
   logic        per_frame_href;
   logic        per_frame_clken;
   logic        cfg_wr;
   logic [3:0]  cfg_mode;
   logic [7:0]  cfg_thresh;
   logic        err_clr;
   logic [3:0]  act_mode;
   logic [7:0]  act_thresh;
   logic        cfg_pending;
   logic        pipe_flush;
   logic        frame_done;
   logic        frame_err;
   logic        err_sticky;
   logic [7:0]  err_count;
   logic [15:0] frame_cnt;
   logic [11:0] last_lines;

   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken,
      output cfg_wr, cfg_mode, cfg_thresh, err_clr,
      input  act_mode, act_thresh, cfg_pending, pipe_flush,
      input  frame_done, frame_err, err_sticky, err_count, frame_cnt, last_lines
   );

   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken,
      input  cfg_wr, cfg_mode, cfg_thresh, err_clr,
      output act_mode, act_thresh, cfg_pending, pipe_flush,
      output frame_done, frame_err, err_sticky, err_count, frame_cnt, last_lines
   );
endinterface

// File: rtl/video_pipe_ctrl.sv
// Frame-synchronous config commit and frame geometry checker for the video chain.
// Host settings take effect only at a frame start; each completed frame is measured.
module video_pipe_ctrl #(
   parameter logic [11:0] IMG_HDISP  = 12'd1920,
   parameter logic [11:0] IMG_VDISP  = 12'd1080,
   parameter logic [3:0]  DEF_MODE   = 4'd0,
   parameter logic [7:0]  DEF_THRESH = 8'd64
) (
   input logic              clk,
   input logic              rst,
   video_pipe_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, BLANK = 2'd2} state_t;

   state_t      state_reg, state_next;
   logic        vsync_d, href_d;
   logic        rise_v, fall_v, fall_h;
   logic        frame_end, line_end, line_real, line_bad_fin, frame_bad, commit;
   logic [11:0] pix_cnt, line_cnt, line_cnt_fin;
   logic        line_bad;
   logic [3:0]  pend_mode;
   logic [7:0]  pend_thresh;

   assign rise_v = bus.per_frame_vsync & ~vsync_d;
   assign fall_v = ~bus.per_frame_vsync & vsync_d;
   assign fall_h = ~bus.per_frame_href & href_d;

   // vsync_d comes out of reset high so a frame already in progress at reset
   // release does not look like a fresh frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_d <= 1'b1;
         href_d  <= 1'b0;
      end else begin
         vsync_d <= bus.per_frame_vsync;
         href_d  <= bus.per_frame_href;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      frame_end  = 1'b0;
      case (state_reg)
         IDLE:    if (rise_v) state_next = ACTIVE;
         ACTIVE:  if (fall_v) begin
                     state_next = BLANK;
                     frame_end  = 1'b1;
                  end
         BLANK:   if (rise_v) state_next = ACTIVE;
         default: state_next = IDLE;
      endcase
   end

   // A vsync fall with href still high closes the open line in the same cycle.
   assign line_end     = (state_reg == ACTIVE) && (fall_h || (fall_v && href_d));
   assign line_real    = line_end && (pix_cnt != 12'd0);
   assign line_cnt_fin = (line_real && line_cnt != 12'hFFF) ? line_cnt + 12'd1 : line_cnt;
   assign line_bad_fin = line_bad | (line_real && pix_cnt != IMG_HDISP);
   assign frame_bad    = line_bad_fin | (line_cnt_fin != IMG_VDISP);
   assign commit       = rise_v && bus.cfg_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt  <= 12'd0;
         line_cnt <= 12'd0;
         line_bad <= 1'b0;
      end else if (frame_end) begin
         pix_cnt  <= 12'd0;
         line_cnt <= 12'd0;
         line_bad <= 1'b0;
      end else if (state_reg == ACTIVE) begin
         if (line_end) begin
            pix_cnt  <= 12'd0;
            line_cnt <= line_cnt_fin;
            line_bad <= line_bad_fin;
         end else if (bus.per_frame_href && bus.per_frame_clken && pix_cnt != 12'hFFF) begin
            pix_cnt <= pix_cnt + 12'd1;
         end
      end
   end

   // The commit uses the pending values held before this cycle, so a write
   // landing on the frame-start cycle waits for the following frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.act_mode    <= DEF_MODE;
         bus.act_thresh  <= DEF_THRESH;
         bus.cfg_pending <= 1'b0;
         bus.pipe_flush  <= 1'b0;
         pend_mode       <= 4'd0;
         pend_thresh     <= 8'd0;
      end else begin
         bus.pipe_flush <= commit && (pend_mode != bus.act_mode);
         if (commit) begin
            bus.act_mode   <= pend_mode;
            bus.act_thresh <= pend_thresh;
         end
         if (bus.cfg_wr) begin
            pend_mode       <= bus.cfg_mode;
            pend_thresh     <= bus.cfg_thresh;
            bus.cfg_pending <= 1'b1;
         end else if (commit) begin
            bus.cfg_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.last_lines <= 12'd0;
         bus.frame_cnt  <= 16'd0;
      end else begin
         bus.frame_done <= frame_end;
         if (frame_end) begin
            bus.frame_err  <= frame_bad;
            bus.last_lines <= line_cnt_fin;
            bus.frame_cnt  <= bus.frame_cnt + 16'd1;
         end
      end
   end

   // A bad frame ending in the same cycle as err_clr still registers as one error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_sticky <= 1'b0;
         bus.err_count  <= 8'd0;
      end else if (frame_end && frame_bad) begin
         bus.err_sticky <= 1'b1;
         if (bus.err_clr)                  bus.err_count <= 8'd1;
         else if (bus.err_count != 8'hFF)  bus.err_count <= bus.err_count + 8'd1;
      end else if (bus.err_clr) begin
         bus.err_sticky <= 1'b0;
         bus.err_count  <= 8'd0;
      end
   end
endmodule
